// File: rtl/traffic_sensor_conditioner_if.sv
// Signal bundle between the raw detectors, the light controller and the sensor conditioner.
// The interface is level-based with no valid/ready handshake. Sensors and starve
// are continuous levels derived from registered state. Raw and light inputs may
// change at any time and are sampled on the next rising clock edge.
interface traffic_sensor_conditioner_if;
  logic       ew_left_raw;
  logic       ew_str_raw;
  logic       ns_raw;
  logic [1:0] ew_left_light;
  logic [1:0] ew_str_light;
  logic [1:0] ns_light;
  logic       ew_left_sensor;
  logic       ew_str_sensor;
  logic       ns_sensor;
  logic [2:0] starve;
  // Per-channel FSM state: [5:4] ew_left, [3:2] ew_str, [1:0] ns.
  logic [5:0] dbg_state;

  modport master (
    output ew_left_raw, ew_str_raw, ns_raw,
    output ew_left_light, ew_str_light, ns_light,
    input  ew_left_sensor, ew_str_sensor, ns_sensor,
    input  starve, dbg_state
  );

  modport slave (
    input  ew_left_raw, ew_str_raw, ns_raw,
    input  ew_left_light, ew_str_light, ns_light,
    output ew_left_sensor, ew_str_sensor, ns_sensor,
    output starve, dbg_state
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Per-channel synchronize, debounce, request-latch and starvation tracking for the
// three vehicle detectors feeding the traffic light controller.
module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES = 3,
  parameter int WAIT_W     = 6,
  parameter int MAX_WAIT   = 20
) (
  input logic clk,
  input logic reset,
  traffic_sensor_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL  = 2'd1,
    REQ   = 2'd2,
    SERVE = 2'd3
  } ch_state_t;

  localparam int                 DEB_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_SAT = '1;
  localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [1:0]         GREEN    = 2'b10;

  // Channel index: 2 = ew_left, 1 = ew_str, 0 = ns (matches starve bit order).
  logic [2:0] raw;
  logic [1:0] light [3];
  logic [2:0] sensor;
  logic [2:0] starve_w;
  logic [5:0] state_w;

  assign raw      = {bus.ew_left_raw, bus.ew_str_raw, bus.ns_raw};
  assign light[2] = bus.ew_left_light;
  assign light[1] = bus.ew_str_light;
  assign light[0] = bus.ns_light;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic              s1;
    logic              s2;
    ch_state_t         state;
    logic [DEB_W-1:0]  deb_ctr;
    logic [WAIT_W-1:0] wait_ctr;

    always_ff @(posedge clk) begin
      if (!reset) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        state    <= IDLE;
        deb_ctr  <= '0;
        wait_ctr <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        case (state)
          IDLE: begin
            if (s2) begin
              state   <= QUAL;
              deb_ctr <= DEB_W'(1);
            end
          end
          QUAL: begin
            // A dropout always wins over qualification on the same edge.
            if (!s2) begin
              state   <= IDLE;
              deb_ctr <= '0;
            end else if (deb_ctr == DEB_LAST) begin
              state    <= REQ;
              deb_ctr  <= '0;
              wait_ctr <= '0;
            end else begin
              deb_ctr <= deb_ctr + 1'b1;
            end
          end
          REQ: begin
            if (light[i] == GREEN) begin
              state    <= SERVE;
              wait_ctr <= '0;
            end else if (wait_ctr != WAIT_SAT) begin
              wait_ctr <= wait_ctr + 1'b1;
            end
          end
          SERVE: begin
            // A car still present when green ends re-requests immediately.
            if (light[i] != GREEN) begin
              if (s2) begin
                state    <= REQ;
                wait_ctr <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    // The request is latched in REQ; in SERVE the live presence lets green end early.
    assign sensor[i]           = (state == REQ) || ((state == SERVE) && s2);
    assign starve_w[i]         = (state == REQ) && (wait_ctr >= WAIT_LIM);
    assign state_w[2*i +: 2]   = state;
  end

  assign bus.ew_left_sensor = sensor[2];
  assign bus.ew_str_sensor  = sensor[1];
  assign bus.ns_sensor      = sensor[0];
  assign bus.starve         = starve_w;
  assign bus.dbg_state      = state_w;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: timed stimulus pushes expected
// outputs, a negedge monitor pops and compares them.
module tb_traffic_sensor_conditioner;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QUAL  = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_SERVE = 2'd3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  traffic_sensor_conditioner_if bus();

  traffic_sensor_conditioner #(
    .DEB_CYCLES(3),
    .WAIT_W(6),
    .MAX_WAIT(20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks
  task automatic goto(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_now(input string name, input logic [2:0] sens,
                            input logic [2:0] stv, input logic [1:0] el,
                            input logic [1:0] es, input logic [1:0] ns);
    exp_q.push_back({sens, stv, el, es, ns});
    name_q.push_back(name);
  endtask

  // Scoreboard monitor: {sensors el/es/ns, starve, state el/es/ns}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] exp_v;
      logic [11:0] act_v;
      string       nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {bus.ew_left_sensor, bus.ew_str_sensor, bus.ns_sensor,
               bus.starve, bus.dbg_state};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s @edge %0d: got sens=%b starve=%b state=%b, expected sens=%b starve=%b state=%b",
                 nm, cyc, act_v[11:9], act_v[8:6], act_v[5:0],
                 exp_v[11:9], exp_v[8:6], exp_v[5:0]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset             = 1'b0;
    bus.ew_left_raw   = 1'b1;
    bus.ew_str_raw    = 1'b1;
    bus.ns_raw        = 1'b1;
    bus.ew_left_light = 2'b00;
    bus.ew_str_light  = 2'b00;
    bus.ns_light      = 2'b00;

    // Reset held over two edges with every detector active.
    goto(2);
    expect_now("reset", 3'b000, 3'b000, S_IDLE, S_IDLE, S_IDLE);
    reset           = 1'b1;
    bus.ew_left_raw = 1'b0;
    bus.ew_str_raw  = 1'b0;
    bus.ns_raw      = 1'b0;
    goto(4);
    expect_now("sync_cleared", 3'b000, 3'b000, S_IDLE, S_IDLE, S_IDLE);

    // Two-sample glitch on ew_str.
    bus.ew_str_raw = 1'b1;
    goto(6);
    bus.ew_str_raw = 1'b0;
    goto(8);
    expect_now("glitch_qual", 3'b000, 3'b000, S_IDLE, S_QUAL, S_IDLE);
    goto(9);
    expect_now("glitch_reject", 3'b000, 3'b000, S_IDLE, S_IDLE, S_IDLE);

    // ns qualification and latch.
    bus.ns_raw = 1'b1;
    goto(13);
    expect_now("ns_qual", 3'b000, 3'b000, S_IDLE, S_IDLE, S_QUAL);
    goto(14);
    expect_now("ns_req", 3'b001, 3'b000, S_IDLE, S_IDLE, S_REQ);
    goto(19);
    bus.ns_raw = 1'b0;
    goto(22);
    expect_now("ns_latched", 3'b001, 3'b000, S_IDLE, S_IDLE, S_REQ);
    goto(24);
    bus.ns_raw = 1'b1;

    // ns serve with live presence.
    goto(29);
    bus.ns_light = 2'b10;
    goto(30);
    expect_now("ns_serve", 3'b001, 3'b000, S_IDLE, S_IDLE, S_SERVE);
    goto(34);
    bus.ns_raw = 1'b0;
    goto(35);
    expect_now("ns_serve_hold", 3'b001, 3'b000, S_IDLE, S_IDLE, S_SERVE);
    goto(36);
    expect_now("ns_serve_empty", 3'b000, 3'b000, S_IDLE, S_IDLE, S_SERVE);
    goto(39);
    bus.ns_light = 2'b01;
    goto(40);
    expect_now("ns_idle", 3'b000, 3'b000, S_IDLE, S_IDLE, S_IDLE);

    // ew_left starvation.
    goto(45);
    bus.ew_left_raw = 1'b1;
    goto(49);
    expect_now("el_qual", 3'b000, 3'b000, S_QUAL, S_IDLE, S_IDLE);
    goto(50);
    expect_now("el_req", 3'b100, 3'b000, S_REQ, S_IDLE, S_IDLE);
    goto(69);
    expect_now("el_wait19", 3'b100, 3'b000, S_REQ, S_IDLE, S_IDLE);
    goto(70);
    expect_now("el_starve", 3'b100, 3'b100, S_REQ, S_IDLE, S_IDLE);
    goto(74);
    expect_now("el_starve_hold", 3'b100, 3'b100, S_REQ, S_IDLE, S_IDLE);
    bus.ew_left_light = 2'b10;
    goto(75);
    expect_now("el_serve_clear", 3'b100, 3'b000, S_SERVE, S_IDLE, S_IDLE);
    goto(79);
    bus.ew_left_light = 2'b00;
    goto(80);
    expect_now("el_rerequest", 3'b100, 3'b000, S_REQ, S_IDLE, S_IDLE);

    // ew_str request, then reset mid-request.
    goto(84);
    bus.ew_str_raw = 1'b1;
    goto(89);
    expect_now("es_req", 3'b110, 3'b000, S_REQ, S_REQ, S_IDLE);
    goto(91);
    reset = 1'b0;
    goto(92);
    expect_now("mid_reset", 3'b000, 3'b000, S_IDLE, S_IDLE, S_IDLE);
    reset = 1'b1;
    goto(96);
    expect_now("requal", 3'b000, 3'b000, S_QUAL, S_QUAL, S_IDLE);
    goto(97);
    expect_now("requal_req", 3'b110, 3'b000, S_REQ, S_REQ, S_IDLE);

    // Green during IDLE/QUAL does not shortcut qualification.
    goto(99);
    bus.ns_light = 2'b10;
    goto(100);
    bus.ns_raw = 1'b1;
    goto(104);
    expect_now("green_in_qual", 3'b110, 3'b000, S_REQ, S_REQ, S_QUAL);
    goto(105);
    expect_now("green_then_req", 3'b111, 3'b000, S_REQ, S_REQ, S_REQ);
    goto(106);
    expect_now("green_then_serve", 3'b111, 3'b000, S_REQ, S_REQ, S_SERVE);

    goto(109);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
